// File: rtl/sram_cycle_pkg.sv
// Shared types and timing limits for the asynchronous-SRAM cycle engine.
package sram_cycle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef logic [3:0] phase_cnt_t;

  localparam int unsigned SETUP_CYC_DEF = 1;
  localparam int unsigned PULSE_CYC_DEF = 2;
  localparam int unsigned HOLD_CYC_DEF  = 1;
  localparam int unsigned PHASE_CYC_MAX = 15;

  // A phase lasting N cycles starts its down-counter at N-1 so it ends on zero.
  function automatic phase_cnt_t phase_load(input int unsigned cycles);
    return phase_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable 4-bit down-counter that times each SETUP/PULSE/HOLD phase.
module sram_phase_timer
  import sram_cycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  phase_cnt_t load_val,
  output logic       done
);

  phase_cnt_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 4'd0);

endmodule

// File: rtl/sram_cycle_ctrl.sv
// Single-word asynchronous-SRAM access engine: setup/strobe/hold pin sequence
// with fully registered pins and a one-cycle completion pulse.
module sram_cycle_ctrl
  import sram_cycle_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
  parameter int unsigned PULSE_CYC = PULSE_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  if (SETUP_CYC < 1 || SETUP_CYC > PHASE_CYC_MAX ||
      PULSE_CYC < 1 || PULSE_CYC > PHASE_CYC_MAX ||
      HOLD_CYC  < 1 || HOLD_CYC  > PHASE_CYC_MAX) begin : g_bad_timing
    $error("sram_cycle_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must each be 1..15");
  end

  localparam phase_cnt_t SETUP_LOAD = phase_load(SETUP_CYC);
  localparam phase_cnt_t PULSE_LOAD = phase_load(PULSE_CYC);
  localparam phase_cnt_t HOLD_LOAD  = phase_load(HOLD_CYC);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                timer_load;
  phase_cnt_t          timer_val;
  logic                timer_done;

  assign req_ready = (state_q == IDLE) && cs_en;

  // Pin values are computed for the state being entered so every pin is a flop.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d     = SETUP;
          write_d     = req_write;
          sram_addr_d = req_addr;
          dq_out_d    = req_wdata;
          dq_oe_d     = req_write;
          ce_n_d      = 1'b0;
          timer_load  = 1'b1;
          timer_val   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (timer_done) begin
          state_d    = PULSE;
          timer_load = 1'b1;
          timer_val  = PULSE_LOAD;
          if (write_q) begin
            we_n_d = 1'b0;
          end else begin
            oe_n_d = 1'b0;
          end
        end
      end
      PULSE: begin
        // Read data is captured on the closing edge of the last strobe cycle.
        if (timer_done) begin
          state_d    = HOLD;
          timer_load = 1'b1;
          timer_val  = HOLD_LOAD;
          oe_n_d     = 1'b1;
          we_n_d     = 1'b1;
          if (!write_q) begin
            rsp_rdata_d = sram_dq_in;
          end
        end
      end
      HOLD: begin
        if (timer_done) begin
          state_d     = IDLE;
          ce_n_d      = 1'b1;
          dq_oe_d     = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  sram_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign busy        = (state_q != IDLE);
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule
